traffic_light_fsm: RTL

Two-road traffic-light controller driven by a periodic one-cycle tick from the clock-enable generator. The main road rests in green. The side road is served on demand from a vehicle sensor, with an optional pedestrian walk phase. All timing is counted in tick pulses, so every flip-flop stays on the single board clock `clk`. Outputs drive the lamp LEDs directly.

---
 rtl/traffic_pkg.sv | 23 ++
 rtl/tick_timer.sv | 28 ++
 rtl/traffic_light_fsm.sv | 134 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared types for the two-road traffic-light controller:
// state codes, lamp patterns and a small sizing helper.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED1     = 3'd2,
    WALK        = 3'd3,
    SIDE_GREEN  = 3'd4,
    SIDE_YELLOW = 3'd5,
    ALLRED2     = 3'd6
  } tl_state_t;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_timer.sv
// Tick counter for the traffic-light phases. Counts enb pulses,
// flags the final tick of a phase and saturates at limit-1.
module tick_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         enb,
  input  logic [W-1:0] limit,
  output logic         done,
  output logic         at_limit
);

  logic [W-1:0] count;

  assign at_limit = (count == limit - W'(1));
  assign done     = enb & at_limit;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enb && !at_limit) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_fsm.sv
// Two-road traffic-light controller, all timing in enb ticks.
// Define TL_PED_WALK_EN to build the pedestrian walk phase.
module traffic_light_fsm
  import traffic_pkg::*;
#(
  parameter int GREEN_TICKS  = 8,
  parameter int YELLOW_TICKS = 3,
  parameter int ALLRED_TICKS = 1,
  parameter int WALK_TICKS   = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enb,
  input  logic       car_side,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] state_o
);

  localparam int TMAX = max2(max2(GREEN_TICKS, YELLOW_TICKS),
                             max2(ALLRED_TICKS, WALK_TICKS));
  localparam int TW = $clog2(TMAX) + 1;

  tl_state_t     state;
  tl_state_t     next;
  logic [TW-1:0] limit;
  logic          done;
  logic          at_limit;
  logic          demand;
  logic          divert;

  tick_timer #(
    .W(TW)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (next != state),
    .enb     (enb),
    .limit   (limit),
    .done    (done),
    .at_limit(at_limit)
  );

`ifdef TL_PED_WALK_EN
  logic ped_pending;

  assign demand = car_side | ped_pending;
  assign divert = ped_pending | ped_req;

  // Entering WALK serves the request, so it wins over a new press.
  always_ff @(posedge clk) begin
    if (reset) begin
      ped_pending <= 1'b0;
    end else if (state != WALK && next == WALK) begin
      ped_pending <= 1'b0;
    end else if (ped_req && state != WALK) begin
      ped_pending <= 1'b1;
    end
  end
`else
  logic unused_ped;

  assign unused_ped = ped_req;
  assign demand     = car_side;
  assign divert     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MAIN_GREEN;
    end else begin
      state <= next;
    end
  end

  always_comb begin
    next  = state;
    limit = TW'(GREEN_TICKS);
    unique case (state)
      MAIN_GREEN: begin
        limit = TW'(GREEN_TICKS);
        if (done && demand) next = MAIN_YELLOW;
      end
      MAIN_YELLOW: begin
        limit = TW'(YELLOW_TICKS);
        if (done) next = ALLRED1;
      end
      ALLRED1: begin
        limit = TW'(ALLRED_TICKS);
        if (done) next = divert ? WALK : SIDE_GREEN;
      end
`ifdef TL_PED_WALK_EN
      WALK: begin
        limit = TW'(WALK_TICKS);
        if (done) next = SIDE_GREEN;
      end
`endif
      SIDE_GREEN: begin
        limit = TW'(GREEN_TICKS);
        if (done) next = SIDE_YELLOW;
      end
      SIDE_YELLOW: begin
        limit = TW'(YELLOW_TICKS);
        if (done) next = ALLRED2;
      end
      ALLRED2: begin
        limit = TW'(ALLRED_TICKS);
        if (done) next = MAIN_GREEN;
      end
      default: next = MAIN_GREEN;
    endcase
  end

  always_comb begin
    main_light = LAMP_R;
    side_light = LAMP_R;
    walk       = 1'b0;
    unique case (state)
      MAIN_GREEN:  main_light = LAMP_G;
      MAIN_YELLOW: main_light = LAMP_Y;
      SIDE_GREEN:  side_light = LAMP_G;
      SIDE_YELLOW: side_light = LAMP_Y;
`ifdef TL_PED_WALK_EN
      WALK:        walk = 1'b1;
`endif
      default: ;
    endcase
  end

  assign state_o = state;

endmodule
